// File: rtl/pattern_gate_stream.sv
// pattern_gate_stream
//   Streaming word classifier. Each accepted WIDTH-bit word is classified
//   under the rule picked by 'mode' and the one-bit result is registered
//   with one cycle of latency. A saturating counter tracks how many results
//   were 1 since reset or the last clear.
//
//   Rules:
//     0 SYM    : whole word is a bit-palindrome and non-zero
//     1 HSYM   : upper and lower halves are each bit-palindromes, non-zero
//     2 POP    : popcount(x) >= THRESH
//     3 REPEAT : x equals the previously accepted word (history valid)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake carrying x and mode
//   x [WIDTH-1:0]         input word
//   mode [1:0]            rule select, sampled with the word
//   clear                 synchronous clear of counter and history
//   out_valid / out_ready output handshake carrying z
//   z                     classification result
//   match_cnt [CNT_W-1:0] saturating count of results equal to 1
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The input side is ready whenever the output register is empty
// or is being drained in the same cycle, so a new word replaces the old
// result with no bubble; while the result is stalled nothing is accepted and
// every output holds.
module pattern_gate_stream #(
  parameter int WIDTH  = 16,
  parameter int THRESH = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = $clog2(WIDTH + 1);
  localparam logic [PW-1:0]    THRESH_W = PW'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] MODE_SYM    = 2'd0;
  localparam logic [1:0] MODE_HSYM   = 2'd1;
  localparam logic [1:0] MODE_POP    = 2'd2;
  localparam logic [1:0] MODE_REPEAT = 2'd3;

  logic             r_out_valid;
  logic             r_z;
  logic [CNT_W-1:0] r_match_cnt;
  logic [WIDTH-1:0] r_hist;
  logic             r_hist_valid;

  logic             w_accept;
  logic             w_sym;
  logic             w_hsym;
  logic [PW-1:0]    w_pop;
  logic             w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign match_cnt = r_match_cnt;

  // Bit-level rule evaluation on the presented word.
  always_comb begin
    w_sym  = 1'b1;
    w_hsym = 1'b1;
    w_pop  = '0;
    for (int i = 0; i < HALF; i++) begin
      if (x[i] != x[WIDTH-1-i]) w_sym = 1'b0;
    end
    // Lower half spans [HALF-1:0], upper half spans [WIDTH-1:HALF].
    for (int i = 0; i < HALF / 2; i++) begin
      if (x[i] != x[HALF-1-i])        w_hsym = 1'b0;
      if (x[HALF+i] != x[WIDTH-1-i])  w_hsym = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {{(PW-1){1'b0}}, x[i]};
    end
  end

  always_comb begin
    w_result = 1'b0;
    case (mode)
      MODE_SYM:    w_result = w_sym && (|x);
      MODE_HSYM:   w_result = w_hsym && (|x);
      MODE_POP:    w_result = (w_pop >= THRESH_W);
      MODE_REPEAT: w_result = r_hist_valid && (x == r_hist);
      default:     w_result = 1'b0;
    endcase
  end

  // Output register. A word accepted during clear is still presented; it is
  // classified against the history as it stood before the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_z         <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counter and history. clear wins over any update, so a word accepted in
  // the clear cycle is neither counted nor remembered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt  <= '0;
      r_hist       <= '0;
      r_hist_valid <= 1'b0;
    end else if (clear) begin
      r_match_cnt  <= '0;
      r_hist       <= '0;
      r_hist_valid <= 1'b0;
    end else if (w_accept) begin
      r_hist       <= x;
      r_hist_valid <= 1'b1;
      if (w_result && (r_match_cnt != CNT_MAX)) begin
        r_match_cnt <= r_match_cnt + 1'b1;
      end
    end
  end

endmodule
